// File: rtl/mem_proto_watchdog.sv
// rtl/mem_proto_watchdog.sv - request/done protocol checker with sticky first-error capture
module mem_proto_watchdog #(
  parameter int TIMEOUT = 64,
  parameter int CW      = 20
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_rd,
  input  logic          req_wr,
  input  logic          done,
  output logic          err,
  output logic [2:0]    err_code,
  output logic [CW-1:0] err_cycle,
  output logic          outstanding
);

  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  // Pre-edge count at which the increment would reach TIMEOUT-1, i.e. the last legal done edge.
  localparam logic [WW-1:0] LAST_CNT = WW'(TIMEOUT - 2);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    ERROR = 2'd2
  } state_t;

  state_t        state;
  logic [WW-1:0] wait_cnt;
  logic [CW-1:0] cyc;
  logic          req;
  logic [2:0]    code;

  assign req = req_rd | req_wr;

  always_comb begin
    code = 3'd0;
    if (state == IDLE || state == WAIT) begin
      if (req_rd && req_wr)
        code = 3'd1;
      else if (state == WAIT && req && !done)
        code = 3'd2;
      else if (state == IDLE && done && !req)
        code = 3'd3;
      else if (state == WAIT && !done && wait_cnt == LAST_CNT)
        code = 3'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      cyc         <= '0;
      err         <= 1'b0;
      err_code    <= 3'd0;
      err_cycle   <= '0;
      outstanding <= 1'b0;
    end else begin
      if (cyc != '1)
        cyc <= cyc + 1'b1;
      case (state)
        IDLE, WAIT: begin
          if (code != 3'd0) begin
            state       <= ERROR;
            err         <= 1'b1;
            err_code    <= code;
            err_cycle   <= cyc;
            outstanding <= 1'b0;
          end else if (state == IDLE) begin
            if (req && !done) begin
              state       <= WAIT;
              wait_cnt    <= '0;
              outstanding <= 1'b1;
            end
          end else begin
            if (done) begin
              if (req) begin
                wait_cnt <= '0;
              end else begin
                state       <= IDLE;
                outstanding <= 1'b0;
              end
            end else begin
              wait_cnt <= wait_cnt + 1'b1;
            end
          end
        end
        default: begin
          state       <= ERROR;
          outstanding <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_proto_watchdog.sv
// tb/tb_mem_proto_watchdog.sv - directed vector bench for mem_proto_watchdog (TIMEOUT=4, CW=8)
module tb_mem_proto_watchdog;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_rd = 1'b0;
  logic       req_wr = 1'b0;
  logic       done = 1'b0;
  logic       err;
  logic [2:0] err_code;
  logic [7:0] err_cycle;
  logic       outstanding;

  int total = 0;
  int bad = 0;

  mem_proto_watchdog #(.TIMEOUT(4), .CW(8)) dut (
    .clk(clk), .rst_n(rst_n), .req_rd(req_rd), .req_wr(req_wr), .done(done),
    .err(err), .err_code(err_code), .err_cycle(err_cycle), .outstanding(outstanding)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic       rd;
    logic       wr;
    logic       dn;
    logic       e;
    logic [2:0] code;
    logic [7:0] cyc;
    logic       o;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic rd, input logic wr, input logic dn,
                     input logic e, input logic [2:0] c, input logic [7:0] cy, input logic o);
    vec_t v;
    v.rst_n = r; v.rd = rd; v.wr = wr; v.dn = dn;
    v.e = e; v.code = c; v.cyc = cy; v.o = o;
    vecs.push_back(v);
  endtask

  task automatic step(input logic r, input logic rd, input logic wr, input logic dn);
    rst_n = r; req_rd = rd; req_wr = wr; done = dn;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic e, input logic [2:0] c,
                       input logic [7:0] cy, input logic o);
    total++;
    if (err !== e || err_code !== c || err_cycle !== cy || outstanding !== o) begin
      bad++;
      $display("FAIL %s: got err=%b code=%0d cycle=%0d out=%b, want err=%b code=%0d cycle=%0d out=%b",
               name, err, err_code, err_cycle, outstanding, e, c, cy, o);
    end
  endtask

  initial begin
    // reset with done high, then idle for 10 cycles
    add(0,0,0,1, 0,0,0,0);
    add(0,0,0,1, 0,0,0,0);
    for (int i = 0; i < 10; i++) add(1,0,0,0, 0,0,0,0);
    // normal read then zero-latency write hit
    add(0,0,0,0, 0,0,0,0);
    add(1,0,0,0, 0,0,0,0);
    add(1,0,0,0, 0,0,0,0);
    add(1,1,0,0, 0,0,0,1);
    add(1,0,0,0, 0,0,0,1);
    add(1,0,0,1, 0,0,0,0);
    add(1,0,0,0, 0,0,0,0);
    add(1,0,1,1, 0,0,0,0);
    add(1,0,0,0, 0,0,0,0);
    // back-to-back
    add(0,0,0,0, 0,0,0,0);
    add(1,1,0,0, 0,0,0,1);
    add(1,1,0,1, 0,0,0,1);
    add(1,1,0,1, 0,0,0,1);
    add(1,1,0,1, 0,0,0,1);
    add(1,0,0,1, 0,0,0,0);
    add(1,0,0,0, 0,0,0,0);
    // timeout: request at cycle 3, no done
    add(0,0,0,0, 0,0,0,0);
    add(1,0,0,0, 0,0,0,0);
    add(1,0,0,0, 0,0,0,0);
    add(1,0,0,0, 0,0,0,0);
    add(1,1,0,0, 0,0,0,1);
    add(1,0,0,0, 0,0,0,1);
    add(1,0,0,0, 0,0,0,1);
    add(1,0,0,0, 1,4,6,0);
    add(1,1,0,0, 1,4,6,0);
    // done at the last legal edge
    add(0,0,0,0, 0,0,0,0);
    add(1,0,0,0, 0,0,0,0);
    add(1,0,0,0, 0,0,0,0);
    add(1,0,0,0, 0,0,0,0);
    add(1,1,0,0, 0,0,0,1);
    add(1,0,0,0, 0,0,0,1);
    add(1,0,0,0, 0,0,0,1);
    add(1,0,0,1, 0,0,0,0);
    add(1,0,0,0, 0,0,0,0);
    // conflict in WAIT beats overlap, then sticky
    add(0,0,0,0, 0,0,0,0);
    add(1,0,0,0, 0,0,0,0);
    add(1,0,0,0, 0,0,0,0);
    add(1,0,0,0, 0,0,0,0);
    add(1,1,0,0, 0,0,0,1);
    add(1,0,0,0, 0,0,0,1);
    add(1,1,1,0, 1,1,5,0);
    add(1,0,0,0, 1,1,5,0);
    add(1,0,0,0, 1,1,5,0);
    add(1,0,0,1, 1,1,5,0);
    // overlap
    add(0,0,0,0, 0,0,0,0);
    add(1,0,1,0, 0,0,0,1);
    add(1,1,0,0, 1,2,1,0);
    // unsolicited done, reset mid-error, fresh request completes
    add(0,0,0,0, 0,0,0,0);
    add(1,0,0,0, 0,0,0,0);
    add(1,0,0,1, 1,3,1,0);
    add(1,0,0,0, 1,3,1,0);
    add(0,1,1,1, 0,0,0,0);
    add(1,1,0,0, 0,0,0,1);
    add(1,0,0,1, 0,0,0,0);
    add(1,0,0,0, 0,0,0,0);
    // reset mid-WAIT, and inputs during reset are not accepted
    add(1,1,0,0, 0,0,0,1);
    add(0,1,0,0, 0,0,0,0);
    add(1,0,0,0, 0,0,0,0);
    add(1,0,0,1, 1,3,1,0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst_n, vecs[i].rd, vecs[i].wr, vecs[i].dn);
      check($sformatf("vec%0d", i), vecs[i].e, vecs[i].code, vecs[i].cyc, vecs[i].o);
    end

    // cycle counter saturates at 255
    step(0,0,0,0);
    for (int i = 0; i < 300; i++) step(1,0,0,0);
    check("sat_idle", 1'b0, 3'd0, 8'd0, 1'b0);
    step(1,0,0,1);
    check("sat_err_cycle", 1'b1, 3'd3, 8'd255, 1'b0);

    // error exactly at cycle 254 is not saturated
    step(0,0,0,0);
    for (int i = 0; i < 254; i++) step(1,0,0,0);
    step(1,1,1,0);
    check("pre_sat_cycle", 1'b1, 3'd1, 8'd254, 1'b0);

    // ERROR state ignores further requests and cycles keep counting silently
    for (int i = 0; i < 5; i++) step(1,1,0,0);
    check("error_frozen", 1'b1, 3'd1, 8'd254, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
